// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one port of a 1024x18 SRAM macro between NUM_REQ
// valid/ready requesters, with a fixed two-cycle read response pipe.
module sram_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4,
  parameter int AW        = 10,
  parameter int DW        = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wmsk,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [AW-1:0]         sram_addr,
  output logic [DW-1:0]         sram_wmsk,
  output logic [DW-1:0]         sram_wdata,
  input  logic [DW-1:0]         sram_rdata,
  output logic                  busy
);

  // Handshake: a command transfers in the cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot, combinational, and never depends on req_ready itself.
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [IW-1:0] last_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          have_last_q;
  logic          grant_any;
  logic [IW-1:0] grant_id;
  logic          grant_we;
  logic          found;
  int            start;
  int            idx;

  logic          s1_rd, s2_rd;
  logic [IW-1:0] s1_id, s2_id;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    found     = 1'b0;
    idx       = 0;
    // Until the first grant after reset there is no previous grantee, so the
    // search starts at the pointer itself rather than one past it.
    start     = have_last_q ? int'(last_q) + 1 : int'(last_q);
    if (arb_en && (|req_valid)) begin
      grant_any = 1'b1;
      if (have_last_q && req_valid[last_q] && (cnt_q < BURST_LAST)) begin
        grant_id = last_q;
        cnt_d    = 4'(cnt_q + 4'd1);
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (start + k) % NUM_REQ;
          if (!found && req_valid[idx]) begin
            found    = 1'b1;
            grant_id = IW'(idx);
          end
        end
        // A sole candidate wins again through the wrap; its count saturates.
        cnt_d = (have_last_q && (grant_id == last_q)) ? cnt_q : 4'd0;
      end
      req_ready[grant_id] = 1'b1;
    end
  end

  assign grant_we = req_we[grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen    <= 1'b1;
      sram_wen    <= 1'b1;
      sram_addr   <= '0;
      sram_wmsk   <= '0;
      sram_wdata  <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      have_last_q <= 1'b0;
      s1_rd       <= 1'b0;
      s1_id       <= '0;
      s2_rd       <= 1'b0;
      s2_id       <= '0;
      rsp_data    <= '0;
    end else begin
      sram_cen <= ~(grant_any & ~grant_we);
      sram_wen <= ~(grant_any & grant_we);
      if (grant_any) begin
        sram_addr   <= req_addr[int'(grant_id)*AW +: AW];
        sram_wmsk   <= req_wmsk[int'(grant_id)*DW +: DW];
        sram_wdata  <= req_wdata[int'(grant_id)*DW +: DW];
        last_q      <= grant_id;
        cnt_q       <= cnt_d;
        have_last_q <= 1'b1;
      end
      s1_rd <= grant_any & ~grant_we;
      s1_id <= grant_id;
      s2_rd <= s1_rd;
      s2_id <= s1_id;
      // The macro presents read data during the cycle after issue.
      if (s1_rd) rsp_data <= sram_rdata;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2_rd) rsp_valid[s2_id] = 1'b1;
  end

  assign busy = s1_rd | s2_rd;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM macro, reference
// memory plus expected-response queue, and one task per scenario.
module tb_sram_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 18;

  logic              clk;
  logic              rst_n;
  logic              arb_en;
  logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wmsk, req_wdata;
  logic [DW-1:0]     rsp_data;
  logic              sram_cen, sram_wen, busy;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wmsk, sram_wdata, sram_rdata;

  logic [DW-1:0]     sram_mem [1024];
  logic [DW-1:0]     ref_mem  [1024];
  logic [DW+1:0]     exp_q[$];

  int tests = 0;
  int fails = 0;

  sram_port_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmsk(req_wmsk), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wmsk(sram_wmsk), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Behavioural macro: array write on the edge, read data visible while cen is low
  always @(posedge clk) begin
    if (!sram_wen)
      sram_mem[sram_addr] <= (sram_mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
  end
  assign sram_rdata = sram_cen ? '0 : sram_mem[sram_addr];

  // Scoreboard: push on read handshakes, pop and compare on rsp_valid
  always @(negedge clk) begin
    logic [DW+1:0] e;
    logic [DW+1:0] obs;
    logic [AW-1:0] a;
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          a = req_addr[i*AW +: AW];
          if (req_we[i])
            ref_mem[a] = (ref_mem[a] & req_wmsk[i*DW +: DW]) | (req_wdata[i*DW +: DW] & ~req_wmsk[i*DW +: DW]);
          else
            exp_q.push_back({2'(i), ref_mem[a]});
        end
      end
      if (rsp_valid != '0) begin
        tests++;
        obs = {(rsp_valid[1] ? 2'd1 : 2'd0), rsp_data};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got id/data %h, required no response", obs);
        end else begin
          e = exp_q.pop_front();
          if (!$onehot(rsp_valid) || obs !== e) begin
            fails++;
            $display("FAIL rsp_data: got rsp_valid=%b id/data=%h, required id/data=%h", rsp_valid, obs, e);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] m, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wmsk[i*DW +: DW] = m;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wmsk  = '0;
    req_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    arb_en = 1'b1;
    clear_reqs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one command and returns #1 after its handshake edge.
  task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] m, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    set_req(i, 1'b1, we, a, m, d);
    tests++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fails++;
      $display("FAIL issue_timeout: requester %0d got no req_ready, required a grant within 20 cycles", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    tests++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding busy=%b, required 0", exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests++;
    if ({sram_cen, sram_wen} !== 2'b11) begin
      fails++; $display("FAIL reset_cen_wen: got %b, required 11", {sram_cen, sram_wen});
    end
    tests++;
    if (sram_addr !== '0 || sram_wmsk !== '0 || sram_wdata !== '0) begin
      fails++; $display("FAIL reset_sram_bus: got addr=%h msk=%h data=%h, required 0", sram_addr, sram_wmsk, sram_wdata);
    end
    tests++;
    if (rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++; $display("FAIL reset_rsp: got rsp_valid=%b rsp_data=%h busy=%b ready=%b, required all 0",
                        rsp_valid, rsp_data, busy, req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 10'h005, 18'h00000, 18'h2AAAA);
    tests++;
    if ({sram_cen, sram_wen} !== 2'b10 || sram_addr !== 10'h005 || sram_wdata !== 18'h2AAAA || sram_wmsk !== '0) begin
      fails++; $display("FAIL write_issue: got cen/wen=%b addr=%h data=%h msk=%h, required 10 005 2aaaa 0",
                        {sram_cen, sram_wen}, sram_addr, sram_wdata, sram_wmsk);
    end
    issue(0, 1'b0, 10'h005, 18'h00000, 18'h00000);
    @(negedge clk);
    tests++;
    if ({sram_cen, sram_wen} !== 2'b01 || rsp_valid !== 2'b00 || busy !== 1'b1) begin
      fails++; $display("FAIL read_issue: got cen/wen=%b rsp_valid=%b busy=%b, required 01 00 1",
                        {sram_cen, sram_wen}, rsp_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b01 || rsp_data !== 18'h2AAAA) begin
      fails++; $display("FAIL read_latency: got rsp_valid=%b data=%h, required 01 2aaaa", rsp_valid, rsp_data);
    end
    @(posedge clk);
    #1;
    wait_idle();
  endtask

  task automatic test_masked_write();
    issue(0, 1'b1, 10'h010, 18'h00000, 18'h3FFFF);
    issue(0, 1'b1, 10'h010, 18'h0FF00, 18'h00000);
    issue(0, 1'b0, 10'h010, 18'h00000, 18'h00000);
    wait_idle();
    tests++;
    if (rsp_data !== 18'h0FF00) begin
      fails++; $display("FAIL masked_write: got %h, required 0ff00", rsp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [9];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    apply_reset();
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h010, '0, '0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== pat[k]) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, pat[k]);
      end
      @(posedge clk);
      #1;
    end
    clear_reqs();
    wait_idle();
  endtask

  task automatic test_sole();
    apply_reset();
    set_req(1, 1'b1, 1'b0, 10'h010, '0, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 2'b10 || (k > 0 && (sram_cen !== 1'b0 || sram_addr !== 10'h010))) begin
        fails++; $display("FAIL sole_grant[%0d]: got ready=%b cen=%b addr=%h, required 10 0 010",
                          k, req_ready, sram_cen, sram_addr);
      end
      @(posedge clk);
      #1;
    end
    clear_reqs();
    wait_idle();
  endtask

  task automatic test_arb_en();
    logic [1:0] pat [3];
    pat = '{2'b01, 2'b01, 2'b10};
    apply_reset();
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h010, '0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 2'b01) begin
        fails++; $display("FAIL en_pre[%0d]: got %b, required 01", k, req_ready);
      end
      @(posedge clk);
      #1;
    end
    arb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 2'b00 || (k > 0 && {sram_cen, sram_wen} !== 2'b11)) begin
        fails++; $display("FAIL en_off[%0d]: got ready=%b cen/wen=%b, required 00 11",
                          k, req_ready, {sram_cen, sram_wen});
      end
      @(posedge clk);
      #1;
    end
    arb_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== pat[k]) begin
        fails++; $display("FAIL en_resume[%0d]: got %b, required %b", k, req_ready, pat[k]);
      end
      @(posedge clk);
      #1;
    end
    clear_reqs();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    issue(0, 1'b0, 10'h005, '0, '0);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL mid_busy: got %b, required 1", busy);
    end
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== '0 || busy !== 1'b0 || {sram_cen, sram_wen} !== 2'b11 ||
          sram_addr !== '0 || rsp_data !== '0) begin
        fails++; $display("FAIL mid_reset[%0d]: got rsp_valid=%b busy=%b cen/wen=%b addr=%h data=%h, required 0 0 11 0 0",
                          k, rsp_valid, busy, {sram_cen, sram_wen}, sram_addr, rsp_data);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        fails++; $display("FAIL mid_drop[%0d]: got rsp_valid=%b busy=%b, required 0 0", k, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    arb_en = 1'b1;
    clear_reqs();
    test_reset();
    test_write_read();
    test_masked_write();
    test_round_robin();
    test_sole();
    test_arb_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
